// File: rtl/pll_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and parameter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pll_pkg;

    typedef enum logic [1:0] {
        PRST   = 2'd0,
        WAIT   = 2'd1,
        STABLE = 2'd2,
        RUN    = 2'd3
    } pll_state_t;

    localparam int unsigned LOCK_CYCLES_DEF    = 1024;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 65536;
    localparam int unsigned PLL_RST_CYCLES_DEF = 16;

    // Largest of three cycle counts; sizes the shared sequencing counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; free-running, both flops clear to 0 under rst.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops to settle metastability.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses pll_rst, qualifies lock for LOCK_CYCLES, then releases sys_rst.
// Latency: sys_rst falls 2 (sync) + 1 (WAIT->STABLE) + LOCK_CYCLES cycles after locked rises.
// Backpressure: none. Optional PLL_RESEED_EN re-pulses pll_rst after TIMEOUT_CYCLES without lock.
module pll_reset_seq
    import pll_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES    = LOCK_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int unsigned PLL_RST_CYCLES = PLL_RST_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] loss_cnt
);

    // One spare bit above the largest terminal count so the counter has headroom.
    localparam int unsigned CNT_W = $clog2(max3(LOCK_CYCLES, TIMEOUT_CYCLES, PLL_RST_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
`ifdef PLL_RESEED_EN
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    pll_state_t       state;
    pll_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             loss_inc;
    logic             lk_s;

    sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (lk_s)
    );

    // Counter holds at all-ones rather than wrapping back to zero.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // Next-state and counter decode; only the synchronised lock is ever looked at.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        loss_inc  = 1'b0;
        case (state)
            PRST: begin
                if (cnt == PRST_LAST) begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            WAIT: begin
                if (lk_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else begin
`ifdef PLL_RESEED_EN
                    // PLL never locked in time: kick it again.
                    if (cnt == TMO_LAST) begin
                        state_nxt = PRST;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
`else
                    cnt_nxt = '0;
`endif
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    // Any dropout restarts qualification from scratch.
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (!lk_s) begin
                    state_nxt = WAIT;
                    loss_inc  = 1'b1;
                end
            end
            default: begin
                state_nxt = PRST;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; outputs are decoded from the next state so
    // they change on the same edge as the state and never depend combinationally on locked.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PRST;
            cnt     <= '0;
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pll_rst <= (state_nxt == PRST);
            sys_rst <= (state_nxt != RUN);
            ready   <= (state_nxt == RUN);
        end
    end

    // Lock-loss counter, saturating at 255 so a flapping PLL stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt <= 8'd0;
        end else if (loss_inc && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: streak-based reference model plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_reset_seq;

    localparam int LOCK = 8;
    localparam int TMO  = 100;
    localparam int PRC  = 16;
`ifdef PLL_RESEED_EN
    localparam bit RESEED = 1'b1;
`else
    localparam bit RESEED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] loss_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pll_reset_seq #(
        .LOCK_CYCLES    (LOCK),
        .TIMEOUT_CYCLES (TMO),
        .PLL_RST_CYCLES (PRC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .locked   (locked),
        .pll_rst  (pll_rst),
        .sys_rst  (sys_rst),
        .ready    (ready),
        .loss_cnt (loss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expressed as "pulse cycles left", "consecutive locked samples",
    // "consecutive unlocked waiting samples" and a running flag.
    bit m_valid = 1'b0;
    bit m_s1, m_s2, m_run, m_lk;
    int m_prst, m_streak, m_lows, m_loss;

    always @(posedge clk) begin
        if (rst) begin
            m_valid  = 1'b1;
            m_s1     = 1'b0;
            m_s2     = 1'b0;
            m_prst   = PRC;
            m_run    = 1'b0;
            m_loss   = 0;
            m_streak = 0;
            m_lows   = 0;
        end else begin
            m_lk = m_s2;
            m_s2 = m_s1;
            m_s1 = locked;
            if (m_prst > 0) begin
                m_prst--;
                m_streak = 0;
                m_lows   = 0;
            end else if (m_run) begin
                if (!m_lk) begin
                    m_run    = 1'b0;
                    m_loss   = (m_loss < 255) ? m_loss + 1 : 255;
                    m_streak = 0;
                    m_lows   = 0;
                end
            end else if (m_lk) begin
                m_lows = 0;
                m_streak++;
                // One sample to notice lock, then LOCK qualified samples.
                if (m_streak == LOCK + 1) begin
                    m_run    = 1'b1;
                    m_streak = 0;
                end
            end else if (m_streak > 0) begin
                m_streak = 0;
                m_lows   = 0;
            end else begin
                m_lows++;
                if (RESEED && m_lows == TMO) begin
                    m_prst = PRC;
                    m_lows = 0;
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pll_rst", pll_rst, (m_prst > 0));
            check("model_sys_rst", sys_rst, !m_run);
            check("model_ready", ready, m_run);
            check("model_loss_cnt", loss_cnt, m_loss);
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int hi;
        int c0;
        int d;
        int rise;
        bit prev;

        // Reset release: 16 pll_rst cycles, then waiting with sys_rst held.
        rst = 1'b1;
        locked = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_sys_rst", sys_rst, 1);
        check("rst_ready", ready, 0);
        check("rst_loss_cnt", loss_cnt, 0);
        rst = 1'b0;
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (pll_rst) hi++;
            @(negedge clk);
        end
        check("prst_width", hi, 16);
        check("wait_pll_rst", pll_rst, 0);
        check("wait_sys_rst", sys_rst, 1);

        // Lock qualification: 2 sync + 1 notice + 8 count.
        locked = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 40 && sys_rst; k++) @(negedge clk);
        check("lock_latency", cyc - c0, 11);
        check("lock_ready", ready, 1);

        // Repeated single-cycle losses in RUN.
        for (int i = 0; i < 300; i++) begin
            locked = 1'b0;
            c0 = cyc;
            @(negedge clk);
            locked = 1'b1;
            for (int k = 0; k < 10 && !sys_rst; k++) @(negedge clk);
            d = cyc - c0;
            if (d < 1 || d > 3) check("loss_reassert_within_3", d, 3);
            else checks++;
            for (int k = 0; k < 40 && !ready; k++) @(negedge clk);
            if (!ready) check("loss_relock", ready, 1);
        end
        check("loss_cnt_saturated", loss_cnt, 255);

        // Reset while running.
        rst = 1'b1;
        @(negedge clk);
        check("run_rst_pll_rst", pll_rst, 1);
        check("run_rst_sys_rst", sys_rst, 1);
        check("run_rst_ready", ready, 0);
        check("run_rst_loss_cnt", loss_cnt, 0);
        locked = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // One-cycle glitch while the qualification count is at 5.
        locked = 1'b1;
        c0 = cyc;
        repeat (6) @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        for (int k = 0; k < 60 && sys_rst; k++) @(negedge clk);
        check("glitch_latency", cyc - c0, 18);
        check("glitch_loss_cnt", loss_cnt, 0);

        // Reset while qualifying, then the full pulse must restart.
        locked = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        locked = 1'b1;
        repeat (5) @(negedge clk);
        check("stable_pre_sys_rst", sys_rst, 1);
        rst = 1'b1;
        @(negedge clk);
        check("stable_rst_pll_rst", pll_rst, 1);
        check("stable_rst_sys_rst", sys_rst, 1);
        check("stable_rst_loss_cnt", loss_cnt, 0);
        rst = 1'b0;
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (pll_rst) hi++;
            @(negedge clk);
        end
        check("stable_rst_prst_width", hi, 16);

        // Lock never arrives: re-pulse only when reseeding is built in.
        locked = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        hi = 0;
        rise = -1;
        prev = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (pll_rst) hi++;
            if (pll_rst && !prev && rise < 0) rise = k;
            prev = pll_rst;
            @(negedge clk);
        end
        check("timeout_pll_rst_cycles", hi, RESEED ? 64 : 16);
        check("timeout_second_rise", rise, RESEED ? 116 : -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 1024: consecutive synced-locked cycles required before reset release.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65536: maximum wait for lock before a PLL re-reset (only with PLL_RESEED_EN).
REQ-003 SHALL have parameter PLL_RST_CYCLES, default 16: width of the pll_rst pulse.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port locked, input, 1: PLL lock indication; asynchronous to clk.
REQ-007 SHALL have port pll_rst, output, 1: reset to the PLL rst input.
REQ-008 SHALL have port sys_rst, output, 1: synchronous active-high reset for the downstream design.
REQ-009 SHALL have port ready, output, 1: high only in state RUN.
REQ-010 SHALL have port loss_cnt, output, 8: saturating count of lock losses seen in RUN.

Function
REQ-011 SHALL synchronise locked through two flops (lk_s); the FSM uses only lk_s.
REQ-012 SHALL implement the states PRST, WAIT, STABLE, RUN.
REQ-013 In PRST, pll_rst SHALL be 1 for exactly PLL_RST_CYCLES cycles, then the FSM SHALL enter WAIT with the counter cleared.
REQ-014 In WAIT, lk_s=1 SHALL move the FSM to STABLE with the counter cleared.
REQ-015 In STABLE, the counter SHALL increment each cycle while lk_s=1; lk_s=0 SHALL return the FSM to WAIT with the counter cleared.
REQ-016 In STABLE, the FSM SHALL enter RUN on the cycle the counter reaches LOCK_CYCLES-1 with lk_s=1.
REQ-017 sys_rst SHALL be 1 in every state except RUN, and SHALL deassert on the first RUN cycle, registered with no combinational path from locked.
REQ-018 In RUN, lk_s=0 SHALL enter WAIT, assert sys_rst on the next cycle, and increment loss_cnt; loss_cnt SHALL saturate at 255.
REQ-019 Counter width SHALL be clog2(max(LOCK_CYCLES, TIMEOUT_CYCLES, PLL_RST_CYCLES))+1, and the counter SHALL never wrap.
REQ-020 A lk_s glitch of one cycle in STABLE SHALL restart qualification; a glitch in RUN SHALL count as a loss.

Reset
REQ-021 rst=1 SHALL force state PRST, counter 0, pll_rst=1, sys_rst=1, ready=0, loss_cnt=0, and both synchroniser flops 0.
REQ-022 rst asserted mid-sequence SHALL take priority over all transitions and restart the full PRST pulse.

Configuration
REQ-023 Macro PLL_RESEED_EN defined: in WAIT, if the counter reaches TIMEOUT_CYCLES-1 with lk_s=0, the FSM SHALL enter PRST and re-pulse pll_rst.
REQ-024 Macro PLL_RESEED_EN undefined: WAIT SHALL wait indefinitely, pll_rst SHALL pulse only after rst, and TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-025 A shared package pll_pkg SHALL hold the state enum (PRST, WAIT, STABLE, RUN) and the default parameter constants.
REQ-026 The two-flop synchroniser SHALL be sub-module sync2, 1 bit, reset to 0.
REQ-027 The FSM, counter and loss counter SHALL reside in pll_reset_seq.

Verification
REQ-028 Reset release scenario: rst for 4 cycles with locked=0, PLL_RST_CYCLES=16 -> pll_rst high for exactly 16 cycles after rst falls, then state WAIT, sys_rst=1.
REQ-029 Lock qualification scenario: LOCK_CYCLES=8, locked rises and stays high -> sys_rst falls exactly 2+1+8 cycles after locked rises (sync, WAIT->STABLE, count); ready=1 on the same cycle.
REQ-030 Glitch scenario: locked dropped for 1 cycle at STABLE count 5 -> returns to WAIT and needs a full 8 more qualified cycles; loss_cnt stays 0.
REQ-031 Loss scenario: in RUN, drop locked 300 times -> sys_rst reasserts within 3 cycles of each drop; loss_cnt ends at 255.
REQ-032 Timeout scenario: PLL_RESEED_EN defined, TIMEOUT_CYCLES=100, locked held 0 -> pll_rst re-pulses 16 cycles every 116 cycles; without the macro, pll_rst stays 0 after the first pulse.
REQ-033 Mid-operation reset scenario: rst asserted in STABLE and in RUN -> PRST on the next cycle, loss_cnt=0, sys_rst=1.
